// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI arbiter states, transfer modes and ADXL345 register map
// Contents: arb_state_t state encoding, WRITE_MODE/READ_MODE, REG_* addresses, spi_cmd() word builder
package spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, GAP = 2'd3} arb_state_t;
  localparam logic [1:0] WRITE_MODE = 2'b00;
  localparam logic [1:0] READ_MODE = 2'b10;
  localparam logic [5:0] REG_DEVID = 6'h00;
  localparam logic [5:0] REG_BW_RATE = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0 = 6'h32;
  function automatic logic [15:0] spi_cmd(input logic [1:0] mode, input logic [5:0] addr, input logic [7:0] data);
    return {mode, addr, data};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after a pointer, with wrap
// Ports: spi_clk/n_rst clock and async active-low reset; req request vector;
//        adv/adv_id move the pointer past adv_id; win_oh/win_id winner (one-hot/binary); any = some req set
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         spi_clk,
  input  logic         n_rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  input  logic [2:0]   adv_id,
  output logic [N-1:0] win_oh,
  output logic [2:0]   win_id,
  output logic         any
);
  logic [2:0] ptr, lo_id, hi_id;
  logic hi_hit;
  // lowest set bit overall is the wrap fallback when nothing is set at or above the pointer
  always_comb begin
    lo_id = '0;
    hi_id = '0;
    hi_hit = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) lo_id = 3'(j);
      if (req[j] && 3'(j) >= ptr) begin
        hi_id = 3'(j);
        hi_hit = 1'b1;
      end
    end
    win_id = hi_hit ? hi_id : lo_id;
    win_oh = {{(N-1){1'b0}}, 1'b1} << win_id;
  end
  assign any = |req;
  always_ff @(posedge spi_clk or negedge n_rst)
    if (!n_rst) ptr <= '0;
    else if (adv) ptr <= adv_id == 3'(N - 1) ? 3'd0 : adv_id + 3'd1;
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one spi_serdes among NUM_REQ requesters with a chip-select gap
// Ports: spi_clk/n_rst clock and async active-low reset; req/req_data requests and 16-bit words;
//        ack/rx_data/err completion to the winner; busy, grant_id status; ser_* serdes handshake
// Optional: define SPI_ARB_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYCLES (ack with err=1, rx_data=8'hFF)
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   spi_clk,
  input  logic                   n_rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rx_data,
  output logic                   err,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   ser_start,
  output logic [15:0]            ser_data_tx,
  input  logic                   ser_done,
  input  logic [7:0]             ser_data_rx
);
  arb_state_t state, nxt;
  logic [3:0] gap_cnt;
  logic [NUM_REQ-1:0] win_oh;
  logic [2:0] win_id;
  logic [15:0] win_word;
  logic any, fin, to_hit;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .spi_clk(spi_clk),
    .n_rst(n_rst),
    .req(req),
    .adv(state == RESP),
    .adv_id(grant_id),
    .win_oh(win_oh),
    .win_id(win_id),
    .any(any)
  );
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) win_word |= {16{win_oh[i]}} & req_data[16*i +: 16];
  end
  // ser_done is only meaningful while ISSUE holds the serdes
  assign fin = state == ISSUE && (ser_done || to_hit);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any ? ISSUE : IDLE;
      ISSUE:   nxt = fin ? RESP : ISSUE;
      RESP:    nxt = GAP_CYCLES == 0 ? IDLE : GAP;
      GAP:     nxt = gap_cnt == 4'(GAP_CYCLES - 1) ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge spi_clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      ack <= '0;
      rx_data <= '0;
      grant_id <= '0;
      ser_start <= 1'b0;
      ser_data_tx <= '0;
    end else begin
      state <= nxt;
      gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
      ack <= fin ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id : '0;
      if (state == IDLE && any) begin
        grant_id <= win_id;
        ser_data_tx <= win_word;
        ser_start <= 1'b1;
      end
      if (fin) begin
        ser_start <= 1'b0;
        rx_data <= ser_done ? ser_data_rx : 8'hFF;
      end
    end
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = to_cnt == TW'(TIMEOUT_CYCLES - 1);
  // counter is zero outside ISSUE, so every entry starts a fresh count
  always_ff @(posedge spi_clk or negedge n_rst)
    if (!n_rst) begin
      to_cnt <= '0;
      err <= 1'b0;
    end else begin
      to_cnt <= state == ISSUE ? to_cnt + TW'(1) : '0;
      err <= fin && !ser_done;
    end
`else
  assign to_hit = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed scoreboard bench for spi_txn_arbiter with a behavioural serdes
module tb_spi_txn_arbiter;
  localparam int NR = 3;
  logic spi_clk = 1'b0;
  logic n_rst = 1'b0;
  logic [NR-1:0] req = '0;
  logic [16*NR-1:0] req_data = '0;
  logic [NR-1:0] ack;
  logic [7:0] rx_data;
  logic err, busy, ser_start;
  logic [2:0] grant_id;
  logic [15:0] ser_data_tx;
  logic ser_done = 1'b0;
  logic [7:0] ser_data_rx = '0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0] id;
    logic [15:0] tx;
    logic [7:0] rx;
    logic er;
  } exp_t;
  exp_t sb[$];
  exp_t got_e;
  always #5 spi_clk = ~spi_clk;
  spi_txn_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .spi_clk(spi_clk),
    .n_rst(n_rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .rx_data(rx_data),
    .err(err),
    .busy(busy),
    .grant_id(grant_id),
    .ser_start(ser_start),
    .ser_data_tx(ser_data_tx),
    .ser_done(ser_done),
    .ser_data_rx(ser_data_rx)
  );
  function automatic logic [7:0] rx_of(input logic [15:0] tx);
    return tx[15:8] ^ 8'hE8;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int id, input logic [15:0] tx, input logic e);
    sb.push_back('{id: 3'(id), tx: tx, rx: e ? 8'hFF : rx_of(tx), er: e});
  endtask
  task automatic wait_ack(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge spi_clk);
      n++;
    end while (ack === '0 && n < lim);
    chk("ack_wait", 32'(n < lim), 1);
  endtask
  task automatic wait_start(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge spi_clk);
      n++;
    end while (ser_start !== 1'b1 && n < lim);
    chk("start_wait", 32'(n < lim), 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_ser_start"}, ser_start, 0);
    chk({tag, "_ser_data_tx"}, ser_data_tx, 0);
  endtask
  // serdes model: done 18 cycles after seeing start, one-cycle DONE state, aborts if start drops
  int sd_st = 0;
  int sd_cnt = 0;
  bit sd_hold = 1'b0;
  logic [15:0] sd_tx = '0;
  always @(posedge spi_clk or negedge n_rst)
    if (!n_rst) begin
      sd_st <= 0;
      sd_cnt <= 0;
      ser_done <= 1'b0;
      ser_data_rx <= '0;
    end else begin
      case (sd_st)
        0: if (ser_start) begin
          sd_st <= 1;
          sd_cnt <= 0;
          sd_tx <= ser_data_tx;
        end
        1: if (!ser_start) sd_st <= 0;
        else if (sd_cnt == 17 && !sd_hold) begin
          ser_done <= 1'b1;
          ser_data_rx <= rx_of(sd_tx);
          sd_st <= 2;
        end else sd_cnt <= sd_cnt + 1;
        default: begin
          ser_done <= 1'b0;
          sd_st <= 0;
        end
      endcase
    end
  logic prev_done = 1'b0;
  always @(negedge spi_clk) begin
    if (n_rst && prev_done) chk("start_low_after_done", ser_start, 0);
    prev_done <= n_rst && ser_done;
    if (n_rst && ack !== '0) begin
      if (sb.size() == 0) chk("unexpected_ack", ack, 0);
      else begin
        got_e = sb.pop_front();
        chk("ack_onehot", ack, 32'(1) << got_e.id);
        chk("rx_data", rx_data, got_e.rx);
        chk("err", err, got_e.er);
        chk("grant_id", grant_id, got_e.id);
        chk("ser_data_tx", sd_tx, got_e.tx);
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    repeat (3) @(negedge spi_clk);
    chk_reset_vals("reset");
    n_rst = 1'b1;
    @(negedge spi_clk);
    req_data = {16'hF000, 16'hB300, 16'hB200};
    push(0, 16'hB200, 1'b0);
    req = 3'b001;
    @(negedge spi_clk);
    chk("start_latency", ser_start, 1);
    chk("single_tx", ser_data_tx, 16'hB200);
    wait_ack(100);
    chk("single_rx", rx_data, 8'h5A);
    req = '0;
    @(negedge spi_clk);
    chk("busy_gap1", busy, 1);
    @(negedge spi_clk);
    chk("busy_gap2", busy, 1);
    @(negedge spi_clk);
    chk("busy_idle", busy, 0);
    n_rst = 1'b0;
    @(negedge spi_clk);
    n_rst = 1'b1;
    req_data = {16'hF000, 16'hB300, 16'h2C09};
    push(0, 16'h2C09, 1'b0);
    push(1, 16'hB300, 1'b0);
    push(2, 16'hF000, 1'b0);
    push(0, 16'h2C09, 1'b0);
    req = 3'b111;
    repeat (4) wait_ack(100);
    req = '0;
    push(2, 16'hF000, 1'b0);
    req = 3'b100;
    wait_ack(100);
    req = '0;
    push(0, 16'h2C09, 1'b0);
    push(2, 16'hF000, 1'b0);
    req = 3'b101;
    wait_ack(100);
    req = 3'b100;
    wait_ack(100);
    req = '0;
    push(1, 16'hB300, 1'b0);
    req = 3'b010;
    wait_start(20);
    repeat (2) @(negedge spi_clk);
    req = '0;
    wait_ack(100);
    repeat (10) @(negedge spi_clk);
    chk("withdraw_idle_busy", busy, 0);
    chk("withdraw_idle_start", ser_start, 0);
    chk("withdraw_sb_empty", sb.size(), 0);
    push(2, 16'hF000, 1'b0);
    req = 3'b100;
    wait_start(20);
    repeat (3) @(negedge spi_clk);
    #2 n_rst = 1'b0;
    #1 chk_reset_vals("midreset");
    sb.delete();
    req = '0;
    @(negedge spi_clk);
    n_rst = 1'b1;
    push(1, 16'hB300, 1'b0);
    push(2, 16'hF000, 1'b0);
    req = 3'b110;
    wait_ack(100);
    req = 3'b100;
    wait_ack(100);
    req = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (5) @(negedge spi_clk);
    sd_hold = 1'b1;
    push(0, 16'h2C09, 1'b1);
    req = 3'b001;
    wait_start(20);
    n = 0;
    while (ser_start === 1'b1 && n < 200) begin
      @(negedge spi_clk);
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_ack", ack, 3'b001);
    req = '0;
    sd_hold = 1'b0;
    repeat (5) @(negedge spi_clk);
    push(1, 16'hB300, 1'b0);
    req = 3'b010;
    wait_ack(100);
    req = '0;
`endif
    repeat (5) @(negedge spi_clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
